// File: rtl/game_state_sequencer_if.sv
// Control-side bundle of the game flow sequencer: screen transition
// requests into the sequencer, displayed state and screen enables out.
`timescale 1ns/1ps

interface game_state_sequencer_if;
    logic       start_req;
    logic       battle_req;
    logic       battle_won;
    logic       battle_lost;
    logic       win_game;
    logic       restart_req;
    logic [1:0] state;
    logic [3:0] screen_en;
    logic       state_change;

    modport master (
        output start_req, battle_req, battle_won, battle_lost, win_game, restart_req,
        input  state, screen_en, state_change
    );

    modport slave (
        input  start_req, battle_req, battle_won, battle_lost, win_game, restart_req,
        output state, screen_en, state_change
    );
endinterface

// File: rtl/game_state_sequencer.sv
// Game flow controller: owns the VGA output, muxes one of four screen
// generators onto it and only switches source at a vertical-sync falling
// edge (or after FRAME_TIMEOUT cycles) so frames are never torn.
// Optional feature macro: GAME_SEQ_BATTLE_COUNT_EN (count battle wins
// towards the END condition, WIN_BATTLES wins needed).
`timescale 1ns/1ps

module game_state_sequencer #(
    parameter int unsigned FRAME_TIMEOUT = 1000000,
    parameter int unsigned WIN_BATTLES   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    game_state_sequencer_if.slave  ctrl,
    input  logic [2:0]             r0,
    input  logic [2:0]             r1,
    input  logic [2:0]             r2,
    input  logic [2:0]             r3,
    input  logic [2:0]             g0,
    input  logic [2:0]             g1,
    input  logic [2:0]             g2,
    input  logic [2:0]             g3,
    input  logic [1:0]             b0,
    input  logic [1:0]             b1,
    input  logic [1:0]             b2,
    input  logic [1:0]             b3,
    input  logic                   hs0,
    input  logic                   hs1,
    input  logic                   hs2,
    input  logic                   hs3,
    input  logic                   vs0,
    input  logic                   vs1,
    input  logic                   vs2,
    input  logic                   vs3,
    output logic [2:0]             r,
    output logic [2:0]             g,
    output logic [1:0]             b,
    output logic                   hs,
    output logic                   vs
);

    typedef enum logic [1:0] {
        ST_START  = 2'b00,
        ST_MAZE   = 2'b01,
        ST_BATTLE = 2'b10,
        ST_END    = 2'b11
    } state_t;

    localparam logic [19:0] TO_LAST = 20'(FRAME_TIMEOUT - 1);

    // The 2-bit win counter saturates at WIN_BATTLES, so it must fit.
    if (WIN_BATTLES == 0 || WIN_BATTLES > 3) begin : g_bad_win_battles
        $error("WIN_BATTLES must be in 1..3");
    end

    state_t      disp_q, disp_d;
    state_t      target_q, target_d;
    logic        pending_q, pending_d;
    logic [19:0] to_cnt_q, to_cnt_d;
    logic        vs_dly;
    logic        state_change_q;
    logic        switch_now;
    logic        win_cond;

    logic [2:0]  sel_r, sel_g;
    logic [1:0]  sel_b;
    logic        sel_hs, sel_vs;

    // Pick the pixel/sync bundle of the currently displayed screen.
    always_comb begin
        sel_r  = r0;
        sel_g  = g0;
        sel_b  = b0;
        sel_hs = hs0;
        sel_vs = vs0;
        case (disp_q)
            ST_MAZE:   begin sel_r = r1; sel_g = g1; sel_b = b1; sel_hs = hs1; sel_vs = vs1; end
            ST_BATTLE: begin sel_r = r2; sel_g = g2; sel_b = b2; sel_hs = hs2; sel_vs = vs2; end
            ST_END:    begin sel_r = r3; sel_g = g3; sel_b = b3; sel_hs = hs3; sel_vs = vs3; end
            default:   ;
        endcase
    end

`ifdef GAME_SEQ_BATTLE_COUNT_EN
    logic [1:0] battle_cnt_q, battle_cnt_d;
    logic       won_accept;

    // Win counter: counts accepted wins, clears when START is displayed again.
    always_comb begin
        win_cond     = ctrl.win_game || ((32'(battle_cnt_q) + 32'd1) == WIN_BATTLES);
        won_accept   = !pending_q && (disp_q == ST_BATTLE) && ctrl.battle_won && !ctrl.battle_lost;
        battle_cnt_d = battle_cnt_q;
        if (switch_now && (target_q == ST_START)) begin
            battle_cnt_d = '0;
        end else if (won_accept && (32'(battle_cnt_q) < WIN_BATTLES)) begin
            battle_cnt_d = battle_cnt_q + 2'd1;
        end
    end

    // Win counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            battle_cnt_q <= '0;
        end else begin
            battle_cnt_q <= battle_cnt_d;
        end
    end
`else
    // Win condition is the external level only.
    always_comb begin
        win_cond = ctrl.win_game;
    end
`endif

    // Next-state logic: accept the event matching the displayed screen when
    // idle; while pending, wait for a VS falling edge or the timeout.
    always_comb begin
        disp_d     = disp_q;
        target_d   = target_q;
        pending_d  = pending_q;
        to_cnt_d   = to_cnt_q;
        switch_now = 1'b0;
        if (!pending_q) begin
            case (disp_q)
                ST_START: begin
                    if (ctrl.start_req) begin
                        target_d  = ST_MAZE;
                        pending_d = 1'b1;
                    end
                end
                ST_MAZE: begin
                    if (ctrl.battle_req) begin
                        target_d  = ST_BATTLE;
                        pending_d = 1'b1;
                    end
                end
                ST_BATTLE: begin
                    if (ctrl.battle_lost) begin
                        target_d  = ST_END;
                        pending_d = 1'b1;
                    end else if (ctrl.battle_won) begin
                        target_d  = win_cond ? ST_END : ST_MAZE;
                        pending_d = 1'b1;
                    end
                end
                ST_END: begin
                    if (ctrl.restart_req) begin
                        target_d  = ST_START;
                        pending_d = 1'b1;
                    end
                end
                default: ;
            endcase
            if (pending_d) begin
                to_cnt_d = '0;
            end
        end else begin
            to_cnt_d = to_cnt_q + 20'd1;
            if ((vs_dly && !sel_vs) || (to_cnt_q == TO_LAST)) begin
                switch_now = 1'b1;
                disp_d     = target_q;
                pending_d  = 1'b0;
            end
        end
    end

    // State register. vs_dly follows the selected VS every cycle so a stale
    // high from an earlier frame can never fake an edge once pending rises.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_q         <= ST_START;
            target_q       <= ST_START;
            pending_q      <= 1'b0;
            to_cnt_q       <= '0;
            vs_dly         <= 1'b1;
            state_change_q <= 1'b0;
        end else begin
            disp_q         <= disp_d;
            target_q       <= target_d;
            pending_q      <= pending_d;
            to_cnt_q       <= to_cnt_d;
            vs_dly         <= sel_vs;
            state_change_q <= switch_now;
        end
    end

    // Registered pixel output from the displayed screen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r  <= '0;
            g  <= '0;
            b  <= '0;
            hs <= 1'b1;
            vs <= 1'b1;
        end else begin
            r  <= sel_r;
            g  <= sel_g;
            b  <= sel_b;
            hs <= sel_hs;
            vs <= sel_vs;
        end
    end

    assign ctrl.state        = disp_q;
    assign ctrl.screen_en    = 4'b0001 << disp_q;
    assign ctrl.state_change = state_change_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed bench for game_state_sequencer (FRAME_TIMEOUT=16, WIN_BATTLES=2).
// Expected values for the win-count scenario depend on
// GAME_SEQ_BATTLE_COUNT_EN, matching the build of the design.
`timescale 1ns/1ps

module tb_game_state_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] r0, r1, r2, r3, g0, g1, g2, g3;
    logic [1:0] b0, b1, b2, b3;
    logic [3:0] hs_in, vs_in;
    logic [2:0] r, g;
    logic [1:0] b;
    logic       hs, vs;
    int         checks = 0;
    int         errors = 0;

    game_state_sequencer_if ctrl_if ();

    game_state_sequencer #(.FRAME_TIMEOUT(16), .WIN_BATTLES(2)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl_if.slave),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .g0(g0), .g1(g1), .g2(g2), .g3(g3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .hs0(hs_in[0]), .hs1(hs_in[1]), .hs2(hs_in[2]), .hs3(hs_in[3]),
        .vs0(vs_in[0]), .vs1(vs_in[1]), .vs2(vs_in[2]), .vs3(vs_in[3]),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // which: 0 start, 1 battle, 2 won, 3 lost, 4 restart
    task automatic pulse(input int which);
        case (which)
            0: ctrl_if.start_req   = 1'b1;
            1: ctrl_if.battle_req  = 1'b1;
            2: ctrl_if.battle_won  = 1'b1;
            3: ctrl_if.battle_lost = 1'b1;
            default: ctrl_if.restart_req = 1'b1;
        endcase
        step();
        ctrl_if.start_req   = 1'b0;
        ctrl_if.battle_req  = 1'b0;
        ctrl_if.battle_won  = 1'b0;
        ctrl_if.battle_lost = 1'b0;
        ctrl_if.restart_req = 1'b0;
    endtask

    task automatic vs_edge(input int src);
        vs_in[src] = 1'b0;
        step();
        vs_in[src] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (ctrl_if.state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", ctrl_if.state); end
        checks++; if (ctrl_if.screen_en !== 4'b0001) begin errors++; $display("FAIL reset_en got %b exp 0001", ctrl_if.screen_en); end
        checks++; if ({r, g, b} !== 8'h00) begin errors++; $display("FAIL reset_rgb got %h exp 00", {r, g, b}); end
        checks++; if ({hs, vs} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b exp 11", {hs, vs}); end
        checks++; if (ctrl_if.state_change !== 1'b0) begin errors++; $display("FAIL reset_chg got %b exp 0", ctrl_if.state_change); end
        rst = 1'b1;
        step();
        checks++; if (r !== 3'd1) begin errors++; $display("FAIL start_pixel got %0d exp 1", r); end
    endtask

    task automatic test_start_switch();
        pulse(0);
        checks++; if (dut.pending_q !== 1'b1) begin errors++; $display("FAIL start_pending got %b exp 1", dut.pending_q); end
        checks++; if (ctrl_if.state !== 2'b00) begin errors++; $display("FAIL start_hold0 got %b exp 00", ctrl_if.state); end
        step();
        step();
        checks++; if (ctrl_if.state !== 2'b00) begin errors++; $display("FAIL start_hold1 got %b exp 00", ctrl_if.state); end
        vs_edge(0);
        checks++; if (ctrl_if.state !== 2'b01) begin errors++; $display("FAIL start_sw got %b exp 01", ctrl_if.state); end
        checks++; if (ctrl_if.screen_en !== 4'b0010) begin errors++; $display("FAIL start_en got %b exp 0010", ctrl_if.screen_en); end
        checks++; if (ctrl_if.state_change !== 1'b1) begin errors++; $display("FAIL start_chg got %b exp 1", ctrl_if.state_change); end
        checks++; if (r !== 3'd1) begin errors++; $display("FAIL start_old_pix got %0d exp 1", r); end
        step();
        checks++; if (ctrl_if.state_change !== 1'b0) begin errors++; $display("FAIL start_chg_once got %b exp 0", ctrl_if.state_change); end
        checks++; if ({r, g, b} !== {3'd2, 3'd6, 2'd1}) begin errors++; $display("FAIL start_new_pix got %h exp %h", {r, g, b}, {3'd2, 3'd6, 2'd1}); end
    endtask

    task automatic test_timeout();
        ctrl_if.battle_req = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            ctrl_if.battle_req = 1'b0;
            if (i == 16) begin
                checks++; if (ctrl_if.state !== 2'b01) begin errors++; $display("FAIL to_early got %b exp 01", ctrl_if.state); end
            end
        end
        checks++; if (ctrl_if.state !== 2'b10) begin errors++; $display("FAIL to_switch got %b exp 10", ctrl_if.state); end
        checks++; if (ctrl_if.state_change !== 1'b1) begin errors++; $display("FAIL to_chg got %b exp 1", ctrl_if.state_change); end
        step();
        checks++; if (r !== 3'd3) begin errors++; $display("FAIL to_pix got %0d exp 3", r); end
    endtask

    task automatic test_lost_priority();
        ctrl_if.battle_won  = 1'b1;
        ctrl_if.battle_lost = 1'b1;
        step();
        ctrl_if.battle_won  = 1'b0;
        ctrl_if.battle_lost = 1'b0;
        vs_edge(2);
        checks++; if (ctrl_if.state !== 2'b11) begin errors++; $display("FAIL lost_prio got %b exp 11", ctrl_if.state); end
        checks++; if (ctrl_if.screen_en !== 4'b1000) begin errors++; $display("FAIL lost_en got %b exp 1000", ctrl_if.screen_en); end
    endtask

    task automatic test_ignore();
        pulse(4);
        vs_edge(3);
        checks++; if (ctrl_if.state !== 2'b00) begin errors++; $display("FAIL restart got %b exp 00", ctrl_if.state); end
        pulse(0);
        vs_edge(0);
        checks++; if (ctrl_if.state !== 2'b01) begin errors++; $display("FAIL to_maze got %b exp 01", ctrl_if.state); end
        pulse(1);
        pulse(4);
        pulse(0);
        checks++; if (ctrl_if.state !== 2'b01) begin errors++; $display("FAIL ign_hold got %b exp 01", ctrl_if.state); end
        vs_edge(1);
        checks++; if (ctrl_if.state !== 2'b10) begin errors++; $display("FAIL ign_final got %b exp 10", ctrl_if.state); end
        step();
        step();
        step();
        checks++; if (ctrl_if.state !== 2'b10) begin errors++; $display("FAIL ign_noqueue got %b exp 10", ctrl_if.state); end
        checks++; if (dut.pending_q !== 1'b0) begin errors++; $display("FAIL ign_pending got %b exp 0", dut.pending_q); end
    endtask

    task automatic test_win_game();
        ctrl_if.win_game = 1'b1;
        pulse(2);
        ctrl_if.win_game = 1'b0;
        vs_edge(2);
        checks++; if (ctrl_if.state !== 2'b11) begin errors++; $display("FAIL win_game got %b exp 11", ctrl_if.state); end
        pulse(4);
        vs_edge(3);
        pulse(0);
        vs_edge(0);
        pulse(1);
        vs_edge(1);
        checks++; if (ctrl_if.state !== 2'b10) begin errors++; $display("FAIL back_battle got %b exp 10", ctrl_if.state); end
    endtask

    task automatic test_battle_count();
        logic [1:0] exp2;
`ifdef GAME_SEQ_BATTLE_COUNT_EN
        exp2 = 2'b11;
`else
        exp2 = 2'b01;
`endif
        pulse(2);
        vs_edge(2);
        checks++; if (ctrl_if.state !== 2'b01) begin errors++; $display("FAIL cnt_win1 got %b exp 01", ctrl_if.state); end
        pulse(1);
        vs_edge(1);
        pulse(2);
        vs_edge(2);
        checks++; if (ctrl_if.state !== exp2) begin errors++; $display("FAIL cnt_win2 got %b exp %b", ctrl_if.state, exp2); end
    endtask

    task automatic test_reset_mid_pending();
        // Only the event matching the displayed screen is taken.
        ctrl_if.start_req   = 1'b1;
        ctrl_if.battle_req  = 1'b1;
        ctrl_if.restart_req = 1'b1;
        step();
        ctrl_if.start_req   = 1'b0;
        ctrl_if.battle_req  = 1'b0;
        ctrl_if.restart_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (dut.to_cnt_q !== 20'd5) begin errors++; $display("FAIL mid_cnt got %0d exp 5", dut.to_cnt_q); end
        rst = 1'b0;
        step();
        checks++; if (ctrl_if.state !== 2'b00) begin errors++; $display("FAIL mid_state got %b exp 00", ctrl_if.state); end
        checks++; if ({hs, vs} !== 2'b11) begin errors++; $display("FAIL mid_sync got %b exp 11", {hs, vs}); end
        checks++; if (dut.pending_q !== 1'b0) begin errors++; $display("FAIL mid_pending got %b exp 0", dut.pending_q); end
        checks++; if (ctrl_if.screen_en !== 4'b0001) begin errors++; $display("FAIL mid_en got %b exp 0001", ctrl_if.screen_en); end
        rst = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++; if (ctrl_if.state !== 2'b00) begin errors++; $display("FAIL mid_discard got %b exp 00", ctrl_if.state); end
    endtask

    initial begin
        r0 = 3'd1; r1 = 3'd2; r2 = 3'd3; r3 = 3'd4;
        g0 = 3'd5; g1 = 3'd6; g2 = 3'd7; g3 = 3'd0;
        b0 = 2'd0; b1 = 2'd1; b2 = 2'd2; b3 = 2'd3;
        hs_in = '1;
        vs_in = '1;
        ctrl_if.start_req   = 1'b0;
        ctrl_if.battle_req  = 1'b0;
        ctrl_if.battle_won  = 1'b0;
        ctrl_if.battle_lost = 1'b0;
        ctrl_if.win_game    = 1'b0;
        ctrl_if.restart_req = 1'b0;
        test_reset();
        test_start_switch();
        test_timeout();
        test_lost_priority();
        test_ignore();
        test_win_game();
        test_battle_count();
        test_reset_mid_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
